sev_seg_scan: RTL and testbench
===============================

Name: sev_seg_scan

Overview:
- Upstream feeder for the 4-bit-to-7-segment decoder.
- Holds a multi-digit hex value and time-multiplexes it onto one decoder instance. Each digit is presented in turn on a 4-bit nibble bus, with a one-hot active-low digit-enable (anode) vector.
- New values are double-buffered: a load request is committed only at a frame boundary, so the display never shows a mix of old and new digits within one frame.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 50000, clock cycles each digit stays enabled (>= 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- value_in  input  4*NUM_DIGITS  hex value to display; digit 0 = bits [3:0] (rightmost).
- dp_in  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
- load  input  1  request to capture value_in/dp_in.
- load_ack  output  1  one-cycle pulse when a pending load is committed to the display.
- busy  output  1  high while a captured load is pending commit.
- digit_nib  output  4  nibble of the active digit; bit 3 = weight 8. Connection to the decoder: w3=digit_nib[3], w0=digit_nib[2], w1=digit_nib[1], w2=digit_nib[0].
- digit_en_n  output  NUM_DIGITS  active-low digit enables, one-hot-low.
- dp_n  output  1  active-low decimal point for the active digit.

Behaviour:
- Reset values: display register 0, pending register 0, busy 0, load_ack 0, prescaler 0, digit index 0, digit_nib 4'h0, digit_en_n all 1s except bit 0 = 0, dp_n 1.
- Prescaler counts 0..REFRESH_DIV-1. On terminal count it wraps to 0 and the digit index advances; the index wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the cycle where the prescaler is at terminal count and the index is NUM_DIGITS-1.
- All outputs are registered. digit_nib, digit_en_n and dp_n change together, one cycle after the index update. Latency from index change to outputs is 1 cycle.
- Load FSM states:
  - IDLE: load=1 captures value_in/dp_in into the pending registers, busy<=1, go to PEND.
  - PEND: at the frame boundary, pending is copied to the display register, load_ack pulses for 1 cycle, busy<=0, go to IDLE.
  - Frame-boundary cycle: the new value is shown starting with digit 0 of the next frame.
- load while PEND: the pending registers are overwritten (last write wins). Still one load_ack per commit.
- load in IDLE on the frame-boundary cycle itself: captured only; commit waits for the next frame boundary (no same-cycle bypass).
- Reset mid-operation: pending data is discarded, no load_ack, the scan restarts at digit 0.
- value_in and dp_in are sampled only on cycles where load=1.

Optional Feature:
- Macro: SEV_SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit is blanked (digit_en_n bit held 1, dp_n 1) when its nibble and all more-significant nibbles in the display register are 0 and its dp bit is 0.
  - Digit 0 is never blanked.
  - Scan timing is unchanged; a blanked slot still occupies REFRESH_DIV cycles.
- Undefined: every digit is always enabled in its slot. Blanking logic is absent.

Test Plan (REFRESH_DIV=4, NUM_DIGITS=4):
1. Reset, hold 40 cycles → digit_en_n cycles 1110,1101,1011,0111 (4 cycles each), digit_nib=0, dp_n=1, busy=0.
2. load=1 with value_in=16'hA5C3, dp_in=4'b0100 → busy=1; load_ack pulses at the next frame boundary. The next frame shows nibbles 3,C,5,A on digits 0..3, with dp_n=0 only on digit 2.
3. Two loads in PEND (16'h1111 then 16'h2222) → exactly one load_ack; the next frame displays 2222.
4. load asserted on the frame-boundary cycle → no commit that frame; load_ack one full frame (16 cycles) later.
5. reset asserted while busy=1 → load_ack never pulses, the display shows 0000, digit_en_n=1110 next cycle.
6. With SEV_SEG_LEADING_ZERO_BLANK_EN: value 16'h0070 → digits 3 and 2 disabled in their slots. Value 16'h0000 → only digit 0 is lit, showing 0.

Source files
------------

// File: rtl/sev_seg_scan_if.sv
// Bus bundle for sev_seg_scan: load handshake towards the feeder and the
// multiplexed digit outputs towards the 7-segment decoder and anode drivers.
interface sev_seg_scan_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    load_ack;
    logic                    busy;
    logic [3:0]              digit_nib;
    logic [NUM_DIGITS-1:0]   digit_en_n;
    logic                    dp_n;

    // Feeder / testbench side
    modport master (
        output value_in, dp_in, load,
        input  load_ack, busy, digit_nib, digit_en_n, dp_n
    );

    // Scanner side
    modport slave (
        input  value_in, dp_in, load,
        output load_ack, busy, digit_nib, digit_en_n, dp_n
    );
endinterface

// File: rtl/sev_seg_scan.sv
// sev_seg_scan: time-multiplexes a double-buffered multi-digit hex value onto
// a single 4-bit-to-7-segment decoder. Loads are committed only at a frame
// boundary so a frame never mixes old and new digits.
// Decoder hookup: w3=digit_nib[3], w0=digit_nib[2], w1=digit_nib[1], w2=digit_nib[0].
// Optional macro SEV_SEG_LEADING_ZERO_BLANK_EN enables leading-zero blanking.
module sev_seg_scan #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input logic           i_clk,
    input logic           i_reset,
    sev_seg_scan_if.slave io_bus
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {StIdle, StPend} state_t;

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    state_t                  r_state;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic                    r_busy;
    logic                    r_ack;
    logic [3:0]              r_nib;
    logic [NUM_DIGITS-1:0]   r_en_n;
    logic                    r_dp_n;

    logic                    w_tc;
    logic                    w_frame;
    logic [3:0]              w_nib;
    logic                    w_dp;
    logic                    w_blank_sel;
    logic [NUM_DIGITS-1:0]   w_en_n;
    logic [NUM_DIGITS-1:0]   w_blank;

    assign w_tc    = (r_presc == PRESC_TC);
    assign w_frame = w_tc && (r_idx == IDX_LAST);

    // Prescaler and digit index: one slot of REFRESH_DIV cycles per digit
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tc) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Load FSM: capture into pending, commit to display at the frame boundary.
    // A load landing on the commit cycle itself is kept pending for the next frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (io_bus.load) begin
                        r_pend_val <= io_bus.value_in;
                        r_pend_dp  <= io_bus.dp_in;
                        r_busy     <= 1'b1;
                        r_state    <= StPend;
                    end
                end
                StPend: begin
                    if (w_frame) begin
                        r_disp_val <= r_pend_val;
                        r_disp_dp  <= r_pend_dp;
                        r_ack      <= 1'b1;
                        r_busy     <= io_bus.load;
                        r_state    <= io_bus.load ? StPend : StIdle;
                    end
                    if (io_bus.load) begin
                        r_pend_val <= io_bus.value_in;
                        r_pend_dp  <= io_bus.dp_in;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef SEV_SEG_LEADING_ZERO_BLANK_EN
    // Blank a digit when it and every more-significant nibble are zero and its dp is off
    always_comb begin
        logic v_zero;
        v_zero  = 1'b1;
        w_blank = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            v_zero     = v_zero && (r_disp_val[4*i +: 4] == 4'h0);
            w_blank[i] = (i != 0) && v_zero && !r_disp_dp[i];
        end
    end
`else
    assign w_blank = '0;
`endif

    // Select nibble, dp and blank flag of the current digit
    always_comb begin
        w_nib       = 4'h0;
        w_dp        = 1'b0;
        w_blank_sel = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (r_idx == IW'(i)) begin
                w_nib       = r_disp_val[4*i +: 4];
                w_dp        = r_disp_dp[i];
                w_blank_sel = w_blank[i];
            end
        end
        w_en_n = ~(NUM_DIGITS'(1) << r_idx);
    end

    // Output register: all digit outputs change together, one cycle after the index
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_nib  <= 4'h0;
            r_en_n <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
            r_dp_n <= 1'b1;
        end else begin
            r_nib  <= w_nib;
            r_en_n <= w_blank_sel ? '1 : w_en_n;
            r_dp_n <= w_blank_sel | ~w_dp;
        end
    end

    assign io_bus.load_ack   = r_ack;
    assign io_bus.busy       = r_busy;
    assign io_bus.digit_nib  = r_nib;
    assign io_bus.digit_en_n = r_en_n;
    assign io_bus.dp_n       = r_dp_n;

endmodule

// File: tb/tb_sev_seg_scan.sv
// Directed testbench for sev_seg_scan with NUM_DIGITS=4, REFRESH_DIV=4.
// Leading-zero blanking steps are compiled only with SEV_SEG_LEADING_ZERO_BLANK_EN.
module tb_sev_seg_scan;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   acks     = 0;

    always #5 clk = ~clk;

    sev_seg_scan_if #(.NUM_DIGITS(ND)) u_if ();

    sev_seg_scan #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD)
    ) u_dut (
        .i_clk  (clk),
        .i_reset(rst),
        .io_bus (u_if)
    );

    // Advance one clock; sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    task automatic chk_digit(input string tag, input logic [3:0] en, input logic [3:0] nib,
                             input logic dpn);
        chk({tag, "_en"}, 32'(u_if.digit_en_n), 32'(en));
        chk({tag, "_nib"}, 32'(u_if.digit_nib), 32'(nib));
        chk({tag, "_dp"}, 32'(u_if.dp_n), 32'(dpn));
    endtask

    // Enable pattern expected k edges after reset release (4 cycles per digit, 1 cycle lag)
    function automatic logic [3:0] exp_en(input int k);
        int idx;
        idx = (k < 1) ? 0 : ((k - 1) / 4) % 4;
        return ~(4'b0001 << idx);
    endfunction

    initial begin
        u_if.load     = 1'b0;
        u_if.value_in = '0;
        u_if.dp_in    = '0;
        rst           = 1'b1;
        repeat (3) tick();
        chk_digit("rst", 4'b1110, 4'h0, 1'b1);
        chk("rst_busy", 32'(u_if.busy), 0);
        chk("rst_ack", 32'(u_if.load_ack), 0);
        rst = 1'b0;
        cyc = 0;

        // 1: idle scan, 40 cycles
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk_digit("t1", exp_en(cyc), 4'h0, 1'b1);
            chk("t1_busy", 32'(u_if.busy), 0);
        end

        // 2: single load, committed at boundary edge 48
        u_if.load     = 1'b1;
        u_if.value_in = 16'hA5C3;
        u_if.dp_in    = 4'b0100;
        tick();
        u_if.load = 1'b0;
        chk("t2_busy", 32'(u_if.busy), 1);
        chk("t2_ack0", 32'(u_if.load_ack), 0);
        while (cyc < 47) tick();
        chk("t2_ack_early", 32'(u_if.load_ack), 0);
        chk("t2_busy_hold", 32'(u_if.busy), 1);
        tick();
        chk("t2_ack", 32'(u_if.load_ack), 1);
        chk("t2_busy_clr", 32'(u_if.busy), 0);
        tick();
        chk("t2_ack_pulse", 32'(u_if.load_ack), 0);
        chk_digit("t2_d0", 4'b1110, 4'h3, 1'b1);
        repeat (4) tick();
        chk_digit("t2_d1", 4'b1101, 4'hC, 1'b1);
        repeat (4) tick();
        chk_digit("t2_d2", 4'b1011, 4'h5, 1'b0);
        repeat (4) tick();
        chk_digit("t2_d3", 4'b0111, 4'hA, 1'b1);

        // 3: two loads while pending, last wins, one ack
        u_if.load     = 1'b1;
        u_if.value_in = 16'h1111;
        u_if.dp_in    = 4'b0000;
        tick();
        u_if.value_in = 16'h2222;
        tick();
        u_if.load = 1'b0;
        chk("t3_busy", 32'(u_if.busy), 1);
        acks = 0;
        while (cyc < 80) begin
            tick();
            if (u_if.load_ack === 1'b1) acks++;
            if (cyc >= 65 && cyc % 4 == 1) chk_digit("t3_dig", exp_en(cyc), 4'h2, 1'b1);
        end
        chk("t3_acks", 32'(acks), 1);

        // 4: load on the frame-boundary cycle (edge 96) commits at edge 112
        while (cyc < 95) tick();
        u_if.load     = 1'b1;
        u_if.value_in = 16'h1234;
        u_if.dp_in    = 4'b0001;
        tick();
        u_if.load = 1'b0;
        chk("t4_busy", 32'(u_if.busy), 1);
        chk("t4_ack0", 32'(u_if.load_ack), 0);
        acks = 0;
        while (cyc < 111) begin
            tick();
            if (u_if.load_ack === 1'b1) acks++;
            if (cyc == 97) chk_digit("t4_old", 4'b1110, 4'h2, 1'b1);
        end
        chk("t4_no_ack", 32'(acks), 0);
        tick();
        chk("t4_ack", 32'(u_if.load_ack), 1);
        chk("t4_busy_clr", 32'(u_if.busy), 0);
        tick();
        chk_digit("t4_d0", 4'b1110, 4'h4, 1'b0);

        // 5: reset while a load is pending
        u_if.load     = 1'b1;
        u_if.value_in = 16'h9876;
        u_if.dp_in    = 4'b1111;
        tick();
        u_if.load = 1'b0;
        chk("t5_busy", 32'(u_if.busy), 1);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_digit("t5_rst", 4'b1110, 4'h0, 1'b1);
        chk("t5_busy_clr", 32'(u_if.busy), 0);
        chk("t5_ack", 32'(u_if.load_ack), 0);
        cyc  = 0;
        acks = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (u_if.load_ack === 1'b1) acks++;
            chk_digit("t5_scan", exp_en(cyc), 4'h0, 1'b1);
        end
        chk("t5_no_ack", 32'(acks), 0);

`ifdef SEV_SEG_LEADING_ZERO_BLANK_EN
        // 6: leading-zero blanking
        u_if.load     = 1'b1;
        u_if.value_in = 16'h0070;
        u_if.dp_in    = 4'b0000;
        tick();
        u_if.load = 1'b0;
        while (cyc < 49) tick();
        chk_digit("t6_d0", 4'b1110, 4'h0, 1'b1);
        repeat (4) tick();
        chk_digit("t6_d1", 4'b1101, 4'h7, 1'b1);
        repeat (4) tick();
        chk("t6_d2_en", 32'(u_if.digit_en_n), 32'hF);
        chk("t6_d2_dp", 32'(u_if.dp_n), 1);
        repeat (4) tick();
        chk("t6_d3_en", 32'(u_if.digit_en_n), 32'hF);
        u_if.load     = 1'b1;
        u_if.value_in = 16'h0000;
        tick();
        u_if.load = 1'b0;
        while (cyc < 65) tick();
        chk_digit("t6z_d0", 4'b1110, 4'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            repeat (4) tick();
            chk("t6z_blank_en", 32'(u_if.digit_en_n), 32'hF);
            chk("t6z_blank_dp", 32'(u_if.dp_n), 1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
